// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for the byte-enabled true dual-port RAM.
package dual_port_ram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int MAX_READ_LATENCY = 3;
    localparam int MAX_DATA_WIDTH   = 512;
    localparam int MAX_BYTES        = MAX_DATA_WIDTH / 8;

    // Callers zero-extend into the widest supported word and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      mask
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dual_port_ram_rd_pipe.sv
// Read-side output pipeline: stage 0 captures the array read, later stages only delay
// data, valid and collision so every port sees the same READ_LATENCY.
module dual_port_ram_rd_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  coll_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  collision
);

    logic [DATA_WIDTH-1:0] data_q  [READ_LATENCY];
    logic                  valid_q [READ_LATENCY];
    logic                  coll_q  [READ_LATENCY];

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
                coll_q[i]  <= 1'b0;
            end
        end else begin
            valid_q[0] <= valid_in;
            coll_q[0]  <= coll_in;
            if (valid_in) begin
                data_q[0] <= data_in;
            end
            // Data moves only alongside a valid, so rdata holds between results.
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                coll_q[i]  <= coll_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rdata     = data_q[READ_LATENCY-1];
    assign rvalid    = valid_q[READ_LATENCY-1];
    assign collision = coll_q[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, A-priority write merge, selectable
// read-during-write behaviour and a latency-aligned address-collision flag.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int        ADDR_WIDTH   = 8,
    parameter int        DATA_WIDTH   = 32,
    parameter int        DEPTH        = 1 << ADDR_WIDTH,
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE     = RDW_READ_FIRST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [DATA_WIDTH/8-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    collision
);

    localparam int                  NB          = DATA_WIDTH / 8;
    localparam int                  AW1         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = AW1'(DEPTH);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("dual_port_ram_be: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("dual_port_ram_be: DATA_WIDTH %0d must be a multiple of 8 up to %0d", DATA_WIDTH, MAX_DATA_WIDTH);
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("dual_port_ram_be: DEPTH %0d does not fit ADDR_WIDTH %0d", DEPTH, ADDR_WIDTH);
    end

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         mask
    );
        return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(new_word),
                                      MAX_BYTES'(mask)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_in_range, b_in_range, same_addr;
    logic                  a_wr, b_wr, both_wr, coll_now;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, both_new;
    logic [DATA_WIDTH-1:0] a_post, b_post, a_rd_word, b_rd_word;
    logic                  b_collision_unused;

    always_comb begin
        a_in_range = {1'b0, a_addr} < DEPTH_LIMIT;
        b_in_range = {1'b0, b_addr} < DEPTH_LIMIT;
        same_addr  = a_addr == b_addr;
        a_wr       = a_en && (a_we != '0) && a_in_range;
        b_wr       = b_en && (b_we != '0) && b_in_range;
        both_wr    = a_wr && b_wr && same_addr;
        coll_now   = a_en && b_en && same_addr && ((a_we != '0) || (b_we != '0));

        a_old    = a_in_range ? mem[a_addr] : '0;
        b_old    = b_in_range ? mem[b_addr] : '0;
        a_new    = merge_word(a_old, a_wdata, a_we);
        b_new    = merge_word(b_old, b_wdata, b_we);
        // Port A is applied last so its enabled bytes win over B's.
        both_new = merge_word(b_new, a_wdata, a_we);

        // Word each address holds after this edge, including the other port's write.
        a_post = both_wr                  ? both_new :
                 a_wr                     ? a_new    :
                 (b_wr && same_addr)      ? b_new    : a_old;
        b_post = both_wr                  ? both_new :
                 b_wr                     ? b_new    :
                 (a_wr && same_addr)      ? a_new    : b_old;

        a_rd_word = '0;
        b_rd_word = '0;
        if (a_in_range) begin
            a_rd_word = (RDW_MODE == RDW_WRITE_FIRST) ? a_post : a_old;
        end
        if (b_in_range) begin
            b_rd_word = (RDW_MODE == RDW_WRITE_FIRST) ? b_post : b_old;
        end
    end

    // NOTE: the array has no reset; writes commit even in a cycle where rst is high.
    always_ff @(posedge clk) begin
        if (both_wr) begin
            mem[a_addr] <= both_new;
        end else begin
            if (a_wr) begin
                mem[a_addr] <= a_new;
            end
            if (b_wr) begin
                mem[b_addr] <= b_new;
            end
        end
    end

    dual_port_ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_a_pipe (
        .clk      (clk),
        .rst      (rst),
        .data_in  (a_rd_word),
        .valid_in (a_en),
        .coll_in  (coll_now),
        .rdata    (a_rdata),
        .rvalid   (a_rvalid),
        .collision(collision)
    );

    dual_port_ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_b_pipe (
        .clk      (clk),
        .rst      (rst),
        .data_in  (b_rd_word),
        .valid_in (b_en),
        .coll_in  (coll_now),
        .rdata    (b_rdata),
        .rvalid   (b_rvalid),
        .collision(b_collision_unused)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: four RAM instances (L1 read-first, L2 read-first, L2 write-first,
// L3 read-first) share one stimulus stream; each scenario checks the relevant instance.
module tb_dual_port_ram_be;
    import dual_port_ram_pkg::*;

    localparam int        LAT  [4] = '{1, 2, 2, 3};
    localparam rdw_mode_e MODE [4] = '{RDW_READ_FIRST, RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_READ_FIRST};

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata [4];
    logic [31:0] b_rdata [4];
    logic        a_rvalid [4];
    logic        b_rvalid [4];
    logic        collision [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dual_port_ram_be #(
            .ADDR_WIDTH  (8),
            .DATA_WIDTH  (32),
            .DEPTH       (200),
            .READ_LATENCY(LAT[g]),
            .RDW_MODE    (MODE[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .a_en     (a_en),
            .a_we     (a_we),
            .a_addr   (a_addr),
            .a_wdata  (a_wdata),
            .a_rdata  (a_rdata[g]),
            .a_rvalid (a_rvalid[g]),
            .b_en     (b_en),
            .b_we     (b_we),
            .b_addr   (b_addr),
            .b_wdata  (b_wdata),
            .b_rdata  (b_rdata[g]),
            .b_rvalid (b_rvalid[g]),
            .collision(collision[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [3:0] we, input logic [7:0] addr, input logic [31:0] data);
        a_en = en; a_we = we; a_addr = addr; a_wdata = data;
    endtask

    task automatic drive_b(input logic en, input logic [3:0] we, input logic [7:0] addr, input logic [31:0] data);
        b_en = en; b_we = we; b_addr = addr; b_wdata = data;
    endtask

    task automatic idle_all();
        drive_a(1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        step();
        step();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (a_rvalid[d] !== 1'b0 || b_rvalid[d] !== 1'b0) begin
                $display("FAIL reset_rvalid dut%0d: a=%b b=%b expected 0 0", d, a_rvalid[d], b_rvalid[d]);
                errors++;
            end
            checks++;
            if (collision[d] !== 1'b0) begin
                $display("FAIL reset_collision dut%0d: got %b expected 0", d, collision[d]);
                errors++;
            end
            checks++;
            if (a_rdata[d] !== 32'h0 || b_rdata[d] !== 32'h0) begin
                $display("FAIL reset_rdata dut%0d: a=%h b=%h expected 0", d, a_rdata[d], b_rdata[d]);
                errors++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive_a(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        step();
        checks++;
        if (a_rvalid[0] !== 1'b1 || collision[0] !== 1'b0) begin
            $display("FAIL basic_write_rvalid: rvalid=%b coll=%b expected 1 0", a_rvalid[0], collision[0]);
            errors++;
        end
        drive_a(1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b1, 4'h0, 8'h10, 32'h0);
        step();
        checks++;
        if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== 32'hDEADBEEF || collision[0] !== 1'b0) begin
            $display("FAIL basic_read: rvalid=%b data=%h coll=%b expected 1 deadbeef 0",
                     b_rvalid[0], b_rdata[0], collision[0]);
            errors++;
        end
        idle_all();
        step();
        checks++;
        if (b_rvalid[0] !== 1'b0 || b_rdata[0] !== 32'hDEADBEEF) begin
            $display("FAIL basic_hold: rvalid=%b data=%h expected 0 deadbeef", b_rvalid[0], b_rdata[0]);
            errors++;
        end
    endtask

    task automatic test_byte_enables();
        drive_a(1'b1, 4'hF, 8'h20, 32'h11223344);
        step();
        drive_a(1'b1, 4'h5, 8'h20, 32'hAABBCCDD);
        step();
        idle_all();
        step();
        // Partial write seen on the same port after two cycles: old word vs merged word.
        checks++;
        if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 32'h11223344) begin
            $display("FAIL be_rdw_read_first: rvalid=%b data=%h expected 1 11223344", a_rvalid[1], a_rdata[1]);
            errors++;
        end
        checks++;
        if (a_rvalid[2] !== 1'b1 || a_rdata[2] !== 32'h11BB33DD) begin
            $display("FAIL be_rdw_write_first: rvalid=%b data=%h expected 1 11bb33dd", a_rvalid[2], a_rdata[2]);
            errors++;
        end
        drive_a(1'b1, 4'h0, 8'h20, 32'h0);
        step();
        checks++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'h11BB33DD) begin
            $display("FAIL be_readback: rvalid=%b data=%h expected 1 11bb33dd", a_rvalid[0], a_rdata[0]);
            errors++;
        end
        idle_all();
        step();
    endtask

    task automatic test_rdw_cross_port();
        drive_a(1'b1, 4'hF, 8'h05, 32'h0);
        step();
        drive_a(1'b1, 4'hF, 8'h05, 32'hCAFEF00D);
        drive_b(1'b1, 4'h0, 8'h05, 32'h0);
        step();
        checks++;
        if (collision[0] !== 1'b1 || b_rdata[0] !== 32'h0) begin
            $display("FAIL rdw_l1: coll=%b data=%h expected 1 00000000", collision[0], b_rdata[0]);
            errors++;
        end
        checks++;
        if (collision[1] !== 1'b0 || b_rvalid[1] !== 1'b0) begin
            $display("FAIL rdw_l2_early: coll=%b rvalid=%b expected 0 0", collision[1], b_rvalid[1]);
            errors++;
        end
        idle_all();
        step();
        checks++;
        if (b_rvalid[1] !== 1'b1 || b_rdata[1] !== 32'h0 || collision[1] !== 1'b1) begin
            $display("FAIL rdw_read_first: rvalid=%b data=%h coll=%b expected 1 00000000 1",
                     b_rvalid[1], b_rdata[1], collision[1]);
            errors++;
        end
        checks++;
        if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'hCAFEF00D || collision[2] !== 1'b1) begin
            $display("FAIL rdw_write_first: rvalid=%b data=%h coll=%b expected 1 cafef00d 1",
                     b_rvalid[2], b_rdata[2], collision[2]);
            errors++;
        end
        step();
        checks++;
        if (collision[1] !== 1'b0 || b_rvalid[1] !== 1'b0) begin
            $display("FAIL rdw_pulse_end: coll=%b rvalid=%b expected 0 0", collision[1], b_rvalid[1]);
            errors++;
        end
    endtask

    task automatic test_write_write();
        drive_a(1'b1, 4'hF, 8'h07, 32'h0);
        step();
        drive_a(1'b1, 4'h3, 8'h07, 32'h0000AAAA);
        drive_b(1'b1, 4'h6, 8'h07, 32'h00BBBB00);
        step();
        checks++;
        if (collision[0] !== 1'b1) begin
            $display("FAIL ww_collision: got %b expected 1", collision[0]);
            errors++;
        end
        idle_all();
        step();
        checks++;
        if (a_rdata[2] !== 32'h00BBAAAA || b_rdata[2] !== 32'h00BBAAAA) begin
            $display("FAIL ww_write_first: a=%h b=%h expected 00bbaaaa", a_rdata[2], b_rdata[2]);
            errors++;
        end
        drive_b(1'b1, 4'h0, 8'h07, 32'h0);
        step();
        checks++;
        if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== 32'h00BBAAAA) begin
            $display("FAIL ww_readback: rvalid=%b data=%h expected 1 00bbaaaa", b_rvalid[0], b_rdata[0]);
            errors++;
        end
        // Two reads of one address are not a conflict.
        drive_a(1'b1, 4'h0, 8'h07, 32'h0);
        step();
        checks++;
        if (collision[0] !== 1'b0 || a_rdata[0] !== 32'h00BBAAAA || b_rdata[0] !== 32'h00BBAAAA) begin
            $display("FAIL rr_no_collision: coll=%b a=%h b=%h expected 0 00bbaaaa 00bbaaaa",
                     collision[0], a_rdata[0], b_rdata[0]);
            errors++;
        end
        idle_all();
        step();
    endtask

    task automatic test_out_of_range();
        drive_a(1'b1, 4'hF, 8'hF0, 32'h12345678);
        step();
        checks++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'h0) begin
            $display("FAIL oor_write: rvalid=%b data=%h expected 1 00000000", a_rvalid[0], a_rdata[0]);
            errors++;
        end
        drive_a(1'b1, 4'h0, 8'hF0, 32'h0);
        step();
        checks++;
        if (a_rvalid[2] !== 1'b1 || a_rdata[2] !== 32'h0) begin
            $display("FAIL oor_write_first: rvalid=%b data=%h expected 1 00000000", a_rvalid[2], a_rdata[2]);
            errors++;
        end
        checks++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'h0) begin
            $display("FAIL oor_read: rvalid=%b data=%h expected 1 00000000", a_rvalid[0], a_rdata[0]);
            errors++;
        end
        idle_all();
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 4'hF, i[7:0], 32'(i));
            step();
        end
        idle_all();
        repeat (4) step();
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                drive_a(1'b1, 4'h0, c[7:0], 32'h0);
            end else begin
                drive_a(1'b0, 4'h0, 8'h00, 32'h0);
            end
            step();
            checks++;
            if (a_rvalid[3] !== (c >= 2 && c < 10)) begin
                $display("FAIL b2b_rvalid cycle %0d: got %b expected %b", c, a_rvalid[3], (c >= 2 && c < 10));
                errors++;
            end
            if (c >= 2 && c < 10) begin
                checks++;
                if (a_rdata[3] !== 32'(c - 2)) begin
                    $display("FAIL b2b_data cycle %0d: got %h expected %h", c, a_rdata[3], 32'(c - 2));
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        drive_a(1'b1, 4'h0, 8'h03, 32'h0);
        step();
        drive_a(1'b1, 4'h0, 8'h04, 32'h0);
        step();
        // The write sampled alongside rst must still land in the array.
        drive_a(1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b1, 4'hF, 8'h09, 32'h00000099);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_all();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_rvalid[3] !== 1'b0 || a_rdata[3] !== 32'h0) begin
                $display("FAIL midflight_flush cycle %0d: rvalid=%b data=%h expected 0 00000000",
                         k, a_rvalid[3], a_rdata[3]);
                errors++;
            end
            step();
        end
        drive_a(1'b1, 4'h0, 8'h03, 32'h0);
        drive_b(1'b1, 4'h0, 8'h09, 32'h0);
        step();
        idle_all();
        step();
        step();
        checks++;
        if (a_rvalid[3] !== 1'b1 || a_rdata[3] !== 32'h3) begin
            $display("FAIL midflight_mem_kept: rvalid=%b data=%h expected 1 00000003", a_rvalid[3], a_rdata[3]);
            errors++;
        end
        checks++;
        if (b_rvalid[3] !== 1'b1 || b_rdata[3] !== 32'h99) begin
            $display("FAIL midflight_write_in_rst: rvalid=%b data=%h expected 1 00000099", b_rvalid[3], b_rdata[3]);
            errors++;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_basic();
        test_byte_enables();
        test_rdw_cross_port();
        test_write_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised true dual-port RAM, successor to the single-width dual-port memory.
- Adds:
  - per-byte write enables
  - configurable read latency (1–3) with an rdata-valid pipeline
  - selectable read-during-write mode
  - deterministic write-write arbitration
  - a registered address-collision flag
- Sits behind two independent masters on one clock (e.g. CPU core and SPI/DMA engine).
- Each port maps 1:1 onto the CPU modport of the existing port interface, plus byte-enable and rvalid.

Parameters:
- ADDR_WIDTH, 8, word address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rdata/rvalid; legal values 1..3.
- RDW_MODE, RDW_READ_FIRST, read-during-write result: RDW_READ_FIRST returns old word, RDW_WRITE_FIRST returns post-write word.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- a_en  in  1  port A access request.
- a_we  in  DATA_WIDTH/8  port A byte write enables; all zero = read.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  a_rdata holds result of a read issued READ_LATENCY cycles earlier.
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B.
- collision  out  1  pulse: same-address conflict detected, aligned with rvalid timing.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On rst: a_rdata, b_rdata = 0; a_rvalid, b_rvalid, collision = 0; all pipeline stages flushed.
  - Memory array is not cleared by rst.
  - rst asserted mid-operation: in-flight reads are discarded (no rvalid); a write sampled in the same cycle as rst is still committed.
- Access acceptance:
  - An access is accepted every cycle en=1; no backpressure; fully pipelined, one access per port per cycle.
  - Read: en=1, we=0. rdata/rvalid appear exactly READ_LATENCY cycles later; rvalid is high for one cycle per read.
  - rdata holds its last value while rvalid=0.
- Writes:
  - en=1, we!=0. Byte i of mem[addr] is updated with wdata[8i+7:8i] when we[i]=1.
  - Write commits at the clock edge where it is sampled.
- Read-during-write reporting:
  - A write also produces rvalid with the RDW_MODE data, so the master can observe the write.
  - Pure reads produce rvalid as well.
  - Every accepted access yields exactly one rvalid.
- Out-of-range address (addr ≥ DEPTH):
  - Write is ignored.
  - Read returns 0 with rvalid=1.
- Read-during-write, same port: RDW_MODE decides.
  - READ_FIRST: old word.
  - WRITE_FIRST: old word with enabled bytes replaced.
- Read on one port, write on the other, same address, same cycle:
  - READ_FIRST: reader gets the old word.
  - WRITE_FIRST: reader gets the merged word (bypass).
- Write-write, same address:
  - Bytes enabled only on A or only on B take that port's data.
  - Bytes enabled on both take port A data (A has priority).
  - In WRITE_FIRST both ports return the final merged word.
- collision:
  - Asserted when a_en & b_en & (a_addr == b_addr) & (a_we != 0 | b_we != 0).
  - Registered through the same READ_LATENCY pipeline, so it aligns with the rvalids of the conflicting accesses.
  - Two reads to the same address do not raise collision.
- Output pipeline:
  - Stage 0 is the array-read register.
  - Stages 1..READ_LATENCY-1 are pure delay registers for data, rvalid and collision.

Decomposition:
- Package dual_port_ram_pkg:
  - rdw_mode_e enum {RDW_READ_FIRST, RDW_WRITE_FIRST}.
  - Function for byte-merge of old/new word under a byte mask.
  - Constant MAX_READ_LATENCY = 3.
- Sub-module dual_port_ram_rd_pipe:
  - Parametrised by DATA_WIDTH and READ_LATENCY.
  - Carries {data, valid, collision} with reset on valid/collision.
  - Instantiated once per port; the collision flag is taken from the port A instance.
- Top: array, write arbitration/merge, bypass muxes, parameter legality assertions (elaboration-time $error on illegal READ_LATENCY or DATA_WIDTH).

Test Plan:
- Basic write/read, L=1:
  - Stimulus: A write addr 0x10 data 0xDEADBEEF we=0xF; next cycle B read 0x10.
  - Response: 1 cycle later b_rdata=0xDEADBEEF, b_rvalid=1 for one cycle, collision=0.
- Byte enables:
  - Stimulus: mem[0x20]=0x11223344; A write we=0x5 data 0xAABBCCDD; then read.
  - Response: 0x11BB33DD.
- RDW_MODE, L=2:
  - Stimulus: mem[5]=0x0; same cycle A write 0xCAFEF00D we=0xF, B read 5.
  - Response, READ_FIRST: B gets 0x0 two cycles later.
  - Response, WRITE_FIRST: B gets 0xCAFEF00D.
  - Both cases: collision=1 aligned with rvalid.
- Write-write arbitration:
  - Stimulus: same cycle, addr 7: A we=0x3 data 0x000000AA_AA (low half 0xAAAA); B we=0x6 data 0x00BBBB00.
  - Response: later read returns 0x00BBAAAA; collision=1.
- Pipeline throughput, L=3:
  - Stimulus: back-to-back A reads of addr 0..7, preloaded with value = addr.
  - Response: rvalid high 8 consecutive cycles starting 3 cycles after the first read, data 0..7 in order.
- Reset mid-flight, L=3:
  - Stimulus: issue 2 reads, assert rst on the next cycle.
  - Response: no rvalid ever for those reads; rdata=0; memory contents preserved on a subsequent read.
